// File: rtl/ysyx_22040759_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_pkg
// Purpose  : Shared definitions for the simulation RAM.
//            - FSM state encoding
//            - access-size codes
//            - byte-strobe mask constants
//            - LFSR seed and step helper used by the optional random-delay build
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040759_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  localparam logic [7:0] STRB_BYTE  = 8'h01;
  localparam logic [7:0] STRB_HALF  = 8'h03;
  localparam logic [7:0] STRB_WORD  = 8'h0F;
  localparam logic [7:0] STRB_DWORD = 8'hFF;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Size codes 4..7 are treated as a full dword.
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    case (size)
      SIZE_BYTE: size_mask = STRB_BYTE;
      SIZE_HALF: size_mask = STRB_HALF;
      SIZE_WORD: size_mask = STRB_WORD;
      default:   size_mask = STRB_DWORD;
    endcase
  endfunction

  // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (taps at bits 7,5,4,3).
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    lfsr_step = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040759_ram_wstrb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_ram_wstrb
// Purpose  : Builds the byte strobe and lane-aligned write data for a
//            right-aligned store of the given size at a byte offset.
// Ports    : size   - access size code (4..7 = dword)
//            offset - byte offset inside the dword (addr[2:0])
//            wdata  - right-aligned store data
//            strb   - 8-bit byte strobe (mask << offset, truncated)
//            sdata  - store data shifted into its byte lanes
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040759_ram_wstrb
  import ysyx_22040759_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  output logic [7:0]  strb,
  output logic [63:0] sdata
);

  // 8-bit result drops any strobe bits shifted past byte 7.
  assign strb  = size_mask(size) << offset;
  assign sdata = wdata << {offset, 3'b000};

endmodule
`default_nettype wire

// File: rtl/ysyx_22040759_sim_ram.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040759_sim_ram
// Purpose  : Single-ported simulation RAM serving an instruction-fetch port
//            and a data port with a fixed (optionally randomised) latency.
//            Data requests win when both ports are valid in IDLE.
// Ports    : clock, reset (sync, active low)
//            if_valid/if_addr        -> if_ready/if_data_read
//            mem_valid/mem_req/mem_addr/mem_data_write/mem_size
//                                    -> mem_ready/mem_data_read
// Config   : define YSYX_22040759_RAM_RANDOM_DELAY_EN to add 0..3 extra
//            cycles per transaction from an 8-bit LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040759_sim_ram
  import ysyx_22040759_pkg::*;
#(
  parameter int          LATENCY    = 2,
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [63:0] BASE       = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic [63:0] if_data_read,
  input  logic        mem_valid,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_data_write,
  input  logic [2:0]  mem_size,
  output logic        mem_ready,
  output logic [63:0] mem_data_read
);

  localparam logic [4:0]  c_LAT_M1 = 5'(LATENCY - 1);
  localparam logic [63:0] c_BYTES  = 64'd8 << DEPTH_LOG2;

  state_t       r_state;
  state_t       w_next_state;
  logic [4:0]   r_cnt;
  logic         r_is_mem;
  logic         r_write;
  logic [63:0]  r_addr;
  logic [63:0]  r_wdata;
  logic [2:0]   r_size;

  logic         w_accept_mem;
  logic         w_accept_if;
  logic         w_accept;
  logic         w_busy;
  logic [4:0]   w_extra;
  logic [4:0]   w_load;

  logic [63:0]  w_offset;
  logic         w_in_range;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [63:0]  w_rword;
  logic [7:0]   w_strb;
  logic [63:0]  w_sdata;
  logic [63:0]  w_merged;

  logic [63:0]  r_mem [0:(1<<DEPTH_LOG2)-1];

  assign w_accept_mem = (r_state == ST_IDLE) && mem_valid;
  assign w_accept_if  = (r_state == ST_IDLE) && !mem_valid && if_valid;
  assign w_accept     = w_accept_mem || w_accept_if;
  assign w_busy       = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_MEM);
  assign w_load       = c_LAT_M1 + w_extra;

`ifdef YSYX_22040759_RAM_RANDOM_DELAY_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_accept) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign w_extra = {3'b000, r_lfsr[1:0]};
`else
  assign w_extra = 5'd0;
`endif

  // A zero load skips BUSY so that LATENCY=1 still gives a one-cycle response.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_load == 5'd0)    w_next_state = ST_RESP;
          else if (w_accept_mem) w_next_state = ST_BUSY_MEM;
          else                   w_next_state = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (r_cnt <= 5'd1) w_next_state = ST_RESP;
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 5'd0;
      r_is_mem <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= 64'd0;
      r_wdata  <= 64'd0;
      r_size   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt    <= w_load;
        r_is_mem <= w_accept_mem;
        r_write  <= w_accept_mem && mem_req;
        r_addr   <= w_accept_mem ? mem_addr : if_addr;
        r_wdata  <= mem_data_write;
        r_size   <= mem_size;
      end else if (w_busy && (r_cnt != 5'd0)) begin
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  // Address decode on the latched request.
  assign w_offset   = r_addr - BASE;
  assign w_in_range = (r_addr >= BASE) && (w_offset < c_BYTES);
  assign w_index    = w_offset[DEPTH_LOG2+2:3];
  assign w_rword    = w_in_range ? r_mem[w_index] : 64'd0;

  ysyx_22040759_ram_wstrb u_wstrb (
    .size   (r_size),
    .offset (r_addr[2:0]),
    .wdata  (r_wdata),
    .strb   (w_strb),
    .sdata  (w_sdata)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_merge
    assign w_merged[8*gi +: 8] = w_strb[gi] ? w_sdata[8*gi +: 8] : w_rword[8*gi +: 8];
  end

  // Array contents survive reset; only the commit is gated by it.
  always_ff @(posedge clock) begin
    if (reset && (r_state == ST_RESP) && r_write && w_in_range) begin
      r_mem[w_index] <= w_merged;
    end
  end

  assign mem_ready     = (r_state == ST_RESP) && r_is_mem;
  assign if_ready      = (r_state == ST_RESP) && !r_is_mem;
  assign mem_data_read = mem_ready ? w_rword : 64'd0;
  assign if_data_read  = if_ready  ? w_rword : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040759_sim_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040759_sim_ram
// Purpose  : Scoreboard bench for ysyx_22040759_sim_ram. Expected latency and
//            read data are queued when a request is driven and compared when
//            the matching ready pulse appears.
// Config   : honours YSYX_22040759_RAM_RANDOM_DELAY_EN (latency model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040759_sim_ram;

  localparam int LAT = 2;
`ifdef YSYX_22040759_RAM_RANDOM_DELAY_EN
  localparam int N_RD = 100;
`else
  localparam int N_RD = 8;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic [63:0] if_addr = 64'd0;
  logic        if_ready;
  logic [63:0] if_data_read;
  logic        mem_valid = 1'b0;
  logic        mem_req = 1'b0;
  logic [63:0] mem_addr = 64'd0;
  logic [63:0] mem_data_write = 64'd0;
  logic [2:0]  mem_size = 3'd0;
  logic        mem_ready;
  logic [63:0] mem_data_read;

  ysyx_22040759_sim_ram #(
    .LATENCY    (LAT),
    .DEPTH_LOG2 (16),
    .BASE       (64'h8000_0000)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_addr        (if_addr),
    .if_ready       (if_ready),
    .if_data_read   (if_data_read),
    .mem_valid      (mem_valid),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data_write (mem_data_write),
    .mem_size       (mem_size),
    .mem_ready      (mem_ready),
    .mem_data_read  (mem_data_read)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_mem;
    int          lat;
    logic [63:0] data;
    logic        chk;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  m_lfsr = 8'hA5;
  int          last_n;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected latency of the next accepted request; steps the LFSR model.
  function automatic int next_lat();
`ifdef YSYX_22040759_RAM_RANDOM_DELAY_EN
    int extra;
    extra  = int'(m_lfsr[1:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    return LAT + extra;
`else
    return LAT;
`endif
  endfunction

  // Waits for the ready of the queue-head transaction, counting edges.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   n;
    logic got;
    e   = exp_q.pop_front();
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clock); #1;
      n++;
      got = e.is_mem ? mem_ready : if_ready;
    end
    last_n = n;
    check({tag, "_lat"}, 64'(n), 64'(e.lat));
    if (got) begin
      if (e.chk) check({tag, "_data"}, e.is_mem ? mem_data_read : if_data_read, e.data);
      check({tag, "_other_rdy"}, {63'd0, e.is_mem ? if_ready : mem_ready}, 64'd0);
      check({tag, "_other_data"}, e.is_mem ? if_data_read : mem_data_read, 64'd0);
    end
  endtask

  task automatic run_mem(input string tag, input logic req, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] size,
                         input logic [63:0] exp_data);
    exp_t e;
    @(posedge clock); #1;
    mem_valid      = 1'b1;
    mem_req        = req;
    mem_addr       = addr;
    mem_data_write = wdata;
    mem_size       = size;
    e = '{is_mem: 1'b1, lat: next_lat(), data: exp_data, chk: !req};
    exp_q.push_back(e);
    wait_resp(tag);
    mem_valid = 1'b0;
    mem_addr  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic run_if(input string tag, input logic [63:0] addr, input logic [63:0] exp_data);
    exp_t e;
    @(posedge clock); #1;
    if_valid = 1'b1;
    if_addr  = addr;
    e = '{is_mem: 1'b0, lat: next_lat(), data: exp_data, chk: 1'b1};
    exp_q.push_back(e);
    wait_resp(tag);
    if_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   t_mem;
    int   lat_sum;
    logic seen;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    check("rst_if_ready",  {63'd0, if_ready},  64'd0);
    check("rst_mem_data",  mem_data_read, 64'd0);
    check("rst_if_data",   if_data_read,  64'd0);
    reset  = 1'b1;
    m_lfsr = 8'hA5;

    // Dword write / read back
    run_mem("clr_w0",  1'b1, 64'h8000_0000, 64'd0, 3'd3, 64'd0);
    run_mem("wr_dw",   1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 3'd3, 64'd0);
    run_mem("rd_dw",   1'b0, 64'h8000_0008, 64'd0, 3'd3, 64'h1122_3344_5566_7788);

    // Sub-word writes into word 0
    run_mem("wr_b",    1'b1, 64'h8000_0003, 64'h0000_0000_0000_00AB, 3'd0, 64'd0);
    run_mem("rd_b",    1'b0, 64'h8000_0000, 64'd0, 3'd3, 64'h0000_0000_AB00_0000);
    run_mem("wr_h",    1'b1, 64'h8000_0006, 64'hFFFF_FFFF_FFFF_BEEF, 3'd1, 64'd0);
    run_mem("rd_h",    1'b0, 64'h8000_0000, 64'd0, 3'd3, 64'hBEEF_0000_AB00_0000);
    // Word at offset 5: strobe truncated to bytes 5..7
    run_mem("wr_w5",   1'b1, 64'h8000_0005, 64'h0000_0000_1122_3344, 3'd2, 64'd0);
    run_mem("rd_w5",   1'b0, 64'h8000_0001, 64'd0, 3'd0, 64'h2233_4400_AB00_0000);

    // Size 5 acts as dword; fetch port ignores low offset bits
    run_mem("wr_sz5",  1'b1, 64'h8000_0010, 64'hCAFE_BABE_0123_4567, 3'd5, 64'd0);
    run_if ("if_rd",   64'h8000_0015, 64'hCAFE_BABE_0123_4567);

    // Top word of the array, then just past it and below BASE
    run_mem("wr_top",  1'b1, 64'h8007_FFF8, 64'h0F0E_0D0C_0B0A_0908, 3'd3, 64'd0);
    run_mem("rd_top",  1'b0, 64'h8007_FFF8, 64'd0, 3'd3, 64'h0F0E_0D0C_0B0A_0908);
    run_mem("wr_oor",  1'b1, 64'h8008_0000, 64'h5555_5555_5555_5555, 3'd3, 64'd0);
    run_mem("rd_oor",  1'b0, 64'h8008_0000, 64'd0, 3'd3, 64'd0);
    run_mem("rd_low",  1'b0, 64'h0000_1000, 64'd0, 3'd3, 64'd0);
    run_mem("rd_base", 1'b0, 64'h8000_0000, 64'd0, 3'd3, 64'h2233_4400_AB00_0000);

    // Both ports valid together: mem first, fetch waits one IDLE cycle
    @(posedge clock); #1;
    mem_valid = 1'b1; mem_req = 1'b0; mem_addr = 64'h8000_0008; mem_size = 3'd3;
    if_valid  = 1'b1; if_addr = 64'h8000_0000;
    e = '{is_mem: 1'b1, lat: next_lat(), data: 64'h1122_3344_5566_7788, chk: 1'b1};
    exp_q.push_back(e);
    wait_resp("arb_mem");
    t_mem     = last_n;
    mem_valid = 1'b0;
    lat_sum   = next_lat();
    e = '{is_mem: 1'b0, lat: lat_sum + 1, data: 64'h2233_4400_AB00_0000, chk: 1'b1};
    exp_q.push_back(e);
    wait_resp("arb_if");
    if_valid = 1'b0;
    check("arb_if_total", 64'(t_mem + last_n), 64'(t_mem + 1 + lat_sum));

    // Reset one cycle after a write is accepted: no pulse, no commit
    @(posedge clock); #1;
    mem_valid = 1'b1; mem_req = 1'b1; mem_addr = 64'h8000_0008;
    mem_data_write = 64'hDEAD_DEAD_DEAD_DEAD; mem_size = 3'd3;
    lat_sum = next_lat();
    @(posedge clock); #1;
    reset = 1'b0;
    mem_valid = 1'b0;
    seen = mem_ready;
    @(posedge clock); #1;
    reset  = 1'b1;
    m_lfsr = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      seen = seen | mem_ready;
      @(posedge clock); #1;
    end
    check("rst_abort_ready", {63'd0, seen}, 64'd0);
    run_mem("rst_rd_old", 1'b0, 64'h8000_0008, 64'd0, 3'd3, 64'h1122_3344_5566_7788);

    // Back-to-back reads for latency sequence
    for (int i = 0; i < N_RD; i++) begin
      run_mem("seq_rd", 1'b0, 64'h8000_0010, 64'd0, 3'd3, 64'hCAFE_BABE_0123_4567);
`ifdef YSYX_22040759_RAM_RANDOM_DELAY_EN
      check("seq_lat_range", {63'd0, (last_n >= 2) && (last_n <= 5)}, 64'd1);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
